// File: rtl/axis_pattern_replay.sv
// Pattern buffer: loads one AXI-Stream pattern (tlast-terminated) into block RAM,
// then replays it as a looping AXI-Stream whose pace is set only by m_axis_tready.
module axis_pattern_replay #(
    parameter int DATA_WIDTH = 256,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    input  logic                  load_start,
    input  logic                  play_en,
    output logic                  loaded,
    output logic                  overflow,
    output logic [ADDR_WIDTH:0]   pattern_len
);

    localparam logic [ADDR_WIDTH:0] FULL_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] LEN_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, LOAD, PLAY, DRAIN} state_t;
    state_t state;

    logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];
    logic [DATA_WIDTH-1:0] mem_q;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic                  rd_valid;
    logic                  rd_last;

    logic [DATA_WIDTH-1:0] skid_data;
    logic                  skid_valid;
    logic                  skid_last;

    logic                  load_hs;
    logic                  pop;
    logic                  rd_en;
    logic                  rd_is_last;
    logic                  last_pending;
    logic [1:0]            fill;

    logic [DATA_WIDTH-1:0] head_data_n;
    logic                  head_valid_n;
    logic                  head_last_n;
    logic [DATA_WIDTH-1:0] skid_data_n;
    logic                  skid_valid_n;
    logic                  skid_last_n;

    assign load_hs      = (state == LOAD) && s_axis_tvalid && s_axis_tready;
    assign pop          = m_axis_tvalid && m_axis_tready;
    assign fill         = 2'(m_axis_tvalid) + 2'(skid_valid) + 2'(rd_valid);
    assign rd_is_last   = ({1'b0, rd_ptr} == (pattern_len - LEN_ONE));
    assign last_pending = (rd_valid && rd_last) || (m_axis_tvalid && m_axis_tlast)
                        || (skid_valid && skid_last);
    // Words in flight (output regs + skid + pending read) never exceed two, so the
    // skid register always has room for a read issued under a stall.
    assign rd_en = ((state == PLAY) || ((state == DRAIN) && !last_pending))
                && ((fill < 2'd2) || pop);

    always_ff @(posedge clk) begin
        if (load_hs) begin
            mem[wr_ptr] <= s_axis_tdata;
        end
        if (rd_en) begin
            mem_q <= mem[rd_ptr];
        end
    end

    always_comb begin
        head_data_n  = m_axis_tdata;
        head_valid_n = m_axis_tvalid;
        head_last_n  = m_axis_tlast;
        skid_data_n  = skid_data;
        skid_valid_n = skid_valid;
        skid_last_n  = skid_last;
        if (pop) begin
            head_data_n  = skid_data;
            head_valid_n = skid_valid;
            head_last_n  = skid_valid && skid_last;
            skid_valid_n = 1'b0;
        end
        if (rd_valid) begin
            if (!head_valid_n) begin
                head_data_n  = mem_q;
                head_valid_n = 1'b1;
                head_last_n  = rd_last;
            end else begin
                skid_data_n  = mem_q;
                skid_valid_n = 1'b1;
                skid_last_n  = rd_last;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            s_axis_tready <= 1'b0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tdata  <= '0;
            loaded        <= 1'b0;
            overflow      <= 1'b0;
            pattern_len   <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            rd_valid      <= 1'b0;
            rd_last       <= 1'b0;
            skid_data     <= '0;
            skid_valid    <= 1'b0;
            skid_last     <= 1'b0;
        end else begin
            m_axis_tdata  <= head_data_n;
            m_axis_tvalid <= head_valid_n;
            m_axis_tlast  <= head_last_n;
            skid_data     <= skid_data_n;
            skid_valid    <= skid_valid_n;
            skid_last     <= skid_last_n;
            rd_valid      <= rd_en;
            if (rd_en) begin
                rd_last <= rd_is_last;
                rd_ptr  <= rd_is_last ? '0 : rd_ptr + 1'b1;
            end

            case (state)
                IDLE: begin
                    if (load_start) begin
                        state         <= LOAD;
                        wr_ptr        <= '0;
                        loaded        <= 1'b0;
                        overflow      <= 1'b0;
                        s_axis_tready <= 1'b1;
                    end else if (play_en && loaded) begin
                        state  <= PLAY;
                        rd_ptr <= '0;
                    end
                end
                LOAD: begin
                    if (load_hs) begin
                        if (s_axis_tlast) begin
                            pattern_len   <= {1'b0, wr_ptr} + LEN_ONE;
                            loaded        <= 1'b1;
                            s_axis_tready <= 1'b0;
                            state         <= IDLE;
                        end else if (&wr_ptr) begin
                            pattern_len   <= FULL_LEN;
                            loaded        <= 1'b1;
                            overflow      <= 1'b1;
                            s_axis_tready <= 1'b0;
                            state         <= IDLE;
                        end else begin
                            wr_ptr <= wr_ptr + 1'b1;
                        end
                    end
                end
                PLAY, DRAIN: begin
                    // The tlast beat completing as replay is released ends the pattern
                    // cleanly, whether or not DRAIN has been entered yet.
                    if (play_en) begin
                        state <= PLAY;
                    end else if (pop && m_axis_tlast) begin
                        state         <= IDLE;
                        m_axis_tvalid <= 1'b0;
                        m_axis_tlast  <= 1'b0;
                        skid_valid    <= 1'b0;
                        skid_last     <= 1'b0;
                        rd_valid      <= 1'b0;
                    end else begin
                        state <= DRAIN;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axis_pattern_replay.sv
// Directed bench for axis_pattern_replay: load, looping replay, stalls, drain,
// overflow, single-word pattern and reset during replay.
module tb_axis_pattern_replay;

    localparam int DW = 32;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] s_axis_tdata;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic          s_axis_tlast;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic          m_axis_tlast;
    logic          load_start;
    logic          play_en;
    logic          loaded;
    logic          overflow;
    logic [AW:0]   pattern_len;

    int n_checks = 0;
    int n_pass   = 0;

    logic [DW-1:0] pat [0:7];
    int plen    = 0;
    int exp_idx = 0;

    always #5 clk = ~clk;

    axis_pattern_replay #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk           (clk),
        .reset         (reset),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .load_start    (load_start),
        .play_en       (play_en),
        .loaded        (loaded),
        .overflow      (overflow),
        .pattern_len   (pattern_len)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pattern(input logic [DW-1:0] base, input int len);
        plen = len;
        for (int i = 0; i < len; i++) pat[i] = base + DW'(i);
    endtask

    task automatic load_words(input int n, input logic [DW-1:0] base, input int last_at,
                              output int accepted);
        logic rdy;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        accepted = 0;
        for (int cyc = 0; cyc < 40 && accepted < n; cyc++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = base + DW'(accepted);
            s_axis_tlast  = (accepted == last_at);
            rdy = s_axis_tready;
            tick();
            if (rdy) accepted++;
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        tick();
    endtask

    task automatic check_load(input string tag, input int acc, input int exp_acc,
                              input logic [AW:0] exp_len, input logic exp_ovf);
        n_checks++;
        if (acc != exp_acc) $display("FAIL %s accepted: got %0d want %0d", tag, acc, exp_acc);
        else n_pass++;
        n_checks++;
        if (pattern_len !== exp_len) $display("FAIL %s pattern_len: got %0d want %0d", tag, pattern_len, exp_len);
        else n_pass++;
        n_checks++;
        if (loaded !== 1'b1) $display("FAIL %s loaded: got %b want 1", tag, loaded);
        else n_pass++;
        n_checks++;
        if (overflow !== exp_ovf) $display("FAIL %s overflow: got %b want %b", tag, overflow, exp_ovf);
        else n_pass++;
        n_checks++;
        if (s_axis_tready !== 1'b0) $display("FAIL %s s_tready_after: got %b want 0", tag, s_axis_tready);
        else n_pass++;
    endtask

    task automatic start_play();
        int edges = 0;
        exp_idx = 0;
        play_en = 1'b1;
        m_axis_tready = 1'b0;
        while (edges < 8 && m_axis_tvalid !== 1'b1) begin
            tick();
            edges++;
        end
        n_checks++;
        if (m_axis_tvalid !== 1'b1 || edges > 3)
            $display("FAIL first_valid_latency: got tvalid=%b after %0d edges want 1 within 3", m_axis_tvalid, edges);
        else n_pass++;
    endtask

    task automatic run_beats(input int n, input bit rnd, input bit nobubble);
        int got = 0;
        bit seen = 0;
        logic pv = 1'b0, pr = 1'b0, pl = 1'b0, rdy;
        logic [DW-1:0] pd = '0;
        for (int cyc = 0; cyc < 400 && got < n; cyc++) begin
            rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            m_axis_tready = rdy;
            if (pv && !pr) begin
                n_checks++;
                if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== pd || m_axis_tlast !== pl)
                    $display("FAIL stall_stable: got v=%b d=%h l=%b want v=1 d=%h l=%b",
                             m_axis_tvalid, m_axis_tdata, m_axis_tlast, pd, pl);
                else n_pass++;
            end
            if (m_axis_tvalid === 1'b1) seen = 1;
            if (nobubble && seen) begin
                n_checks++;
                if (m_axis_tvalid !== 1'b1) $display("FAIL no_bubble: got tvalid=%b want 1", m_axis_tvalid);
                else n_pass++;
            end
            if (m_axis_tvalid === 1'b1 && rdy) begin
                n_checks++;
                if (m_axis_tdata !== pat[exp_idx] || m_axis_tlast !== (exp_idx == plen - 1))
                    $display("FAIL beat[%0d]: got d=%h l=%b want d=%h l=%b", exp_idx,
                             m_axis_tdata, m_axis_tlast, pat[exp_idx], exp_idx == plen - 1);
                else n_pass++;
                exp_idx = (exp_idx + 1) % plen;
                got++;
            end
            pv = m_axis_tvalid; pr = rdy; pd = m_axis_tdata; pl = m_axis_tlast;
            tick();
        end
        n_checks++;
        if (got != n) $display("FAIL beat_count: got %0d want %0d", got, n);
        else n_pass++;
    endtask

    task automatic drain_play();
        int n_exp = plen - exp_idx;
        int got = 0;
        bit done = 0;
        bit late_valid = 0;
        play_en = 1'b0;
        m_axis_tready = 1'b0;
        tick();
        m_axis_tready = 1'b1;
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            if (m_axis_tvalid === 1'b1) begin
                n_checks++;
                if (m_axis_tdata !== pat[exp_idx] || m_axis_tlast !== (exp_idx == plen - 1))
                    $display("FAIL drain_beat[%0d]: got d=%h l=%b want d=%h l=%b", exp_idx,
                             m_axis_tdata, m_axis_tlast, pat[exp_idx], exp_idx == plen - 1);
                else n_pass++;
                if (m_axis_tlast === 1'b1) done = 1;
                exp_idx = (exp_idx + 1) % plen;
                got++;
            end
            tick();
        end
        n_checks++;
        if (got != n_exp || !done) $display("FAIL drain_count: got %0d (tlast=%0d) want %0d", got, done, n_exp);
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            if (m_axis_tvalid !== 1'b0) late_valid = 1;
            tick();
        end
        n_checks++;
        if (late_valid) $display("FAIL drain_idle: got tvalid after tlast want 0");
        else n_pass++;
        m_axis_tready = 1'b0;
    endtask

    task automatic test_reset();
        bit any_valid = 0;
        reset = 1'b1;
        s_axis_tdata = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
        m_axis_tready = 1'b0; load_start = 1'b0; play_en = 1'b0;
        tick(); tick();
        reset = 1'b0;
        n_checks++;
        if (s_axis_tready !== 1'b0 || m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0 || m_axis_tdata !== '0)
            $display("FAIL reset_axis: got sr=%b mv=%b ml=%b md=%h want 0 0 0 0",
                     s_axis_tready, m_axis_tvalid, m_axis_tlast, m_axis_tdata);
        else n_pass++;
        n_checks++;
        if (loaded !== 1'b0 || overflow !== 1'b0 || pattern_len !== '0)
            $display("FAIL reset_status: got loaded=%b ovf=%b len=%0d want 0 0 0", loaded, overflow, pattern_len);
        else n_pass++;
        play_en = 1'b1;
        m_axis_tready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (m_axis_tvalid !== 1'b0) any_valid = 1;
            tick();
        end
        n_checks++;
        if (any_valid) $display("FAIL play_unloaded: got tvalid=1 want 0");
        else n_pass++;
        play_en = 1'b0;
        m_axis_tready = 1'b0;
    endtask

    task automatic test_load4();
        int acc;
        load_words(4, 32'hA000_0000, 3, acc);
        set_pattern(32'hA000_0000, 4);
        check_load("load4", acc, 4, 4'd4, 1'b0);
    endtask

    task automatic test_play_continuous();
        start_play();
        run_beats(10, 1'b0, 1'b1);
        drain_play();
    endtask

    task automatic test_play_random_ready();
        start_play();
        run_beats(12, 1'b1, 1'b0);
        drain_play();
    endtask

    task automatic test_drain_mid();
        start_play();
        run_beats(2, 1'b0, 1'b1);
        drain_play();
    endtask

    task automatic test_single_word();
        int acc;
        load_words(1, 32'hB0B0_B0B0, 0, acc);
        set_pattern(32'hB0B0_B0B0, 1);
        check_load("load1", acc, 1, 4'd1, 1'b0);
        start_play();
        run_beats(6, 1'b0, 1'b1);
        drain_play();
    endtask

    task automatic test_overflow();
        int acc;
        load_words(10, 32'hC000_0000, -1, acc);
        set_pattern(32'hC000_0000, 8);
        check_load("overflow", acc, 8, 4'd8, 1'b1);
        start_play();
        run_beats(10, 1'b0, 1'b1);
        drain_play();
    endtask

    task automatic test_exact_fill();
        int acc;
        load_words(8, 32'hD000_0000, 7, acc);
        set_pattern(32'hD000_0000, 8);
        check_load("exact_fill", acc, 8, 4'd8, 1'b0);
    endtask

    task automatic test_reset_mid_play();
        int acc;
        bit any_valid = 0;
        load_words(4, 32'hA000_0000, 3, acc);
        set_pattern(32'hA000_0000, 4);
        check_load("reload4", acc, 4, 4'd4, 1'b0);
        start_play();
        run_beats(3, 1'b0, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++;
        if (m_axis_tvalid !== 1'b0 || loaded !== 1'b0 || pattern_len !== '0)
            $display("FAIL reset_mid_play: got tvalid=%b loaded=%b len=%0d want 0 0 0",
                     m_axis_tvalid, loaded, pattern_len);
        else n_pass++;
        for (int i = 0; i < 8; i++) begin
            if (m_axis_tvalid !== 1'b0) any_valid = 1;
            tick();
        end
        n_checks++;
        if (any_valid) $display("FAIL play_after_reset: got tvalid=1 want 0");
        else n_pass++;
        play_en = 1'b0;
        m_axis_tready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_load4();
        test_play_continuous();
        test_play_random_ready();
        test_drain_mid();
        test_single_word();
        test_overflow();
        test_exact_fill();
        test_reset_mid_play();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
